// File: rtl/cla_arb_pkg.sv
// Shared constants and types for the two-requester arbitrated sequential adder.
//   SLICE_W : bits added per sequencer step (one lookahead slice)
//   NUM_REQ : number of requesters behind the round-robin arbiter
//   state_t : sequencer states
package cla_arb_pkg;

  localparam int SLICE_W = 3;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    RESP
  } state_t;

endpackage

// File: rtl/cla_arb_seq_if.sv
// Request/response bundle of cla_arb_seq.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   req_a/req_b         : packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_cin             : per-requester carry-in
//   rsp_valid/rsp_ready : result handshake
//   rsp_id/rsp_sum/rsp_cout : owning requester, sum and carry-out
// master = requester/consumer side, slave = adder side.
interface cla_arb_seq_if #(
  parameter int WIDTH = 12
);
  import cla_arb_pkg::*;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic                     rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/cla_slice3.sv
// Purely combinational 3-bit carry-lookahead slice.
//   a, b : 3-bit operands
//   cin  : carry into bit 0
//   s    : 3-bit sum
//   cout : carry out of bit 2 (c3)
module cla_slice3 (
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic       cin,
  output logic [2:0] s,
  output logic       cout
);

  logic [2:0] g;
  logic [2:0] p;
  logic       c1;
  logic       c2;
  logic       c3;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from cin; no ripple between bits.
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c2, c1, cin};
  assign cout = c3;

endmodule

// File: rtl/cla_arb_seq.sv
// Round-robin arbitrated adder: accepts one operation from either of two
// requesters, adds it 3 bits per cycle through a single lookahead slice,
// and presents the registered result until the consumer takes it.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : cla_arb_seq_if slave modport (request and response handshakes)
module cla_arb_seq #(
  parameter int WIDTH = 12
) (
  input  logic         clk,
  input  logic         rst,
  cla_arb_seq_if.slave bus
);
  import cla_arb_pkg::*;

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state;
  logic [KW-1:0]      k;
  logic               carry;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   res_r;
  logic [WIDTH-1:0]   res_nxt;
  logic               id_r;
  logic               last;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               rid_q;

  logic [NUM_REQ-1:0] grant;
  logic               gid;
  logic               accept;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_s;
  logic               sl_c;

  // Contention goes to the requester not served last; otherwise to the
  // single valid one.
  always_comb begin
    grant = '0;
    if (&bus.req_valid) gid = ~last;
    else                gid = bus.req_valid[1];
    if (|bus.req_valid) grant[gid] = 1'b1;
  end

  assign bus.req_ready = (state == IDLE && !rst) ? grant : '0;
  assign accept        = |(bus.req_valid & bus.req_ready);

  assign sl_a = a_r[SLICE_W*k +: SLICE_W];
  assign sl_b = b_r[SLICE_W*k +: SLICE_W];

  cla_slice3 u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .s    (sl_s),
    .cout (sl_c)
  );

  // Result with the current slice merged in; lets the final ADD cycle load
  // the output register without an extra cycle.
  always_comb begin
    res_nxt = res_r;
    res_nxt[SLICE_W*k +: SLICE_W] = sl_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      res_r  <= '0;
      id_r   <= 1'b0;
      last   <= 1'b1;
      sum_q  <= '0;
      cout_q <= 1'b0;
      rid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r   <= bus.req_a[gid*WIDTH +: WIDTH];
            b_r   <= bus.req_b[gid*WIDTH +: WIDTH];
            id_r  <= gid;
            carry <= bus.req_cin[gid];
            k     <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          res_r <= res_nxt;
          carry <= sl_c;
          k     <= k + KW'(1);
          if (k == KW'(NSLICE - 1)) begin
            k      <= '0;
            sum_q  <= res_nxt;
            cout_q <= sl_c;
            rid_q  <= id_r;
            state  <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            last  <= rid_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_id    = rid_q;

endmodule

// File: tb/tb_cla_arb_seq.sv
module tb_cla_arb_seq;
  import cla_arb_pkg::*;

  localparam int W  = 12;
  localparam int NS = W / 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cla_arb_seq_if #(.WIDTH(W)) bus ();

  cla_arb_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         id;
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t        sb[$];
  int          gq[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned acc_cyc  = 0;
  int unsigned n_rsp    = 0;
  logic        busy     = 1'b0;
  logic        last_m   = 1'b1;
  logic        rsp_seen = 1'b0;
  logic        p_hold   = 1'b0;
  logic [W-1:0] p_sum;
  logic        p_cout;
  logic        p_id;
  logic [1:0]  acc_pend = 2'b00;
  logic [W-1:0] l_sum;
  logic        l_cout;
  logic        l_id;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    model.id   = id;
    model.sum  = t[W-1:0];
    model.cout = t[W];
  endfunction

  // Monitor: reference arbiter/busy model, scoreboard push on accept,
  // pop and compare on response handshake.
  always @(negedge clk) begin
    logic       g;
    logic [1:0] er;
    exp_t       e;
    acc_pend = 2'b00;
    if (rst) begin
      sb.delete();
      busy = 1'b0; last_m = 1'b1; rsp_seen = 1'b0; p_hold = 1'b0;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_sum",   bus.rsp_sum, 0);
      chk("rst_rsp_cout",  bus.rsp_cout, 0);
      chk("rst_rsp_id",    bus.rsp_id, 0);
    end else begin
      g  = (&bus.req_valid) ? ~last_m : bus.req_valid[1];
      er = 2'b00;
      if (!busy && |bus.req_valid) er[g] = 1'b1;
      chk("req_ready", bus.req_ready, er);
      if (!busy) chk("rsp_valid_idle", bus.rsp_valid, 0);
      if (!busy && |bus.req_valid) begin
        sb.push_back(model(g, bus.req_a[g*W +: W], bus.req_b[g*W +: W], bus.req_cin[g]));
        gq.push_back(int'(g));
        busy = 1'b1;
        acc_cyc = cyc + 1;
        acc_pend[g] = 1'b1;
      end
      if (bus.rsp_valid) begin
        if (!rsp_seen) begin
          chk("latency", cyc - acc_cyc, NS);
          chk("rsp_pending", sb.size() > 0, 1);
          rsp_seen = 1'b1;
        end
        if (p_hold) begin
          chk("hold_sum",  bus.rsp_sum, p_sum);
          chk("hold_cout", bus.rsp_cout, p_cout);
          chk("hold_id",   bus.rsp_id, p_id);
        end
        if (bus.rsp_ready) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_id",   bus.rsp_id, e.id);
            chk("rsp_sum",  bus.rsp_sum, e.sum);
            chk("rsp_cout", bus.rsp_cout, e.cout);
            last_m = e.id;
          end
          l_sum = bus.rsp_sum; l_cout = bus.rsp_cout; l_id = bus.rsp_id;
          busy = 1'b0; rsp_seen = 1'b0; p_hold = 1'b0;
          n_rsp++;
        end else begin
          p_hold = 1'b1;
          p_sum = bus.rsp_sum; p_cout = bus.rsp_cout; p_id = bus.rsp_id;
        end
      end
    end
  end

  task automatic wait_rsps(input int unsigned tgt, input int unsigned budget);
    int unsigned t = 0;
    while (n_rsp < tgt && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("rsp_count", n_rsp, tgt);
  endtask

  task automatic wait_acc(input int i);
    int unsigned t = 0;
    while (t < 100) begin
      @(posedge clk); #1;
      if (acc_pend[i]) break;
      t++;
    end
    chk("accept_seen", acc_pend[i], 1);
  endtask

  task automatic drive(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
    bus.req_cin[i]      = cin;
    bus.req_valid[i]    = 1'b1;
  endtask

  task automatic single(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int unsigned base;
    base = n_rsp;
    @(posedge clk); #1;
    drive(i, a, b, cin);
    wait_acc(i);
    bus.req_valid[i] = 1'b0;
    wait_rsps(base + 1, 100);
  endtask

  task automatic do_reset(input int unsigned n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int unsigned base;
    int unsigned t;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0;
    bus.rsp_ready = 1'b1;

    // Reset: ready must stay low even with requests pending.
    bus.req_valid = 2'b11;
    repeat (3) @(posedge clk);
    #1 bus.req_valid = 2'b00;
    rst = 1'b0;

    // Directed sums (carry across slices, wrap, full carry chain).
    single(0, 12'h007, 12'h001, 1'b0);
    chk("d1_sum", l_sum, 12'h008); chk("d1_cout", l_cout, 0); chk("d1_id", l_id, 0);
    single(1, 12'hFFF, 12'h001, 1'b0);
    chk("d2_sum", l_sum, 12'h000); chk("d2_cout", l_cout, 1); chk("d2_id", l_id, 1);
    single(1, 12'hFFF, 12'hFFF, 1'b1);
    chk("d3_sum", l_sum, 12'hFFF); chk("d3_cout", l_cout, 1);

    // Continuous contention from reset: grants alternate starting with 0.
    do_reset(2);
    gq.delete();
    base = n_rsp;
    drive(0, 12'h100, 12'h0FF, 1'b1);
    drive(1, 12'hABC, 12'h544, 1'b0);
    t = 0;
    while (gq.size() < 4 && t < 200) begin
      @(posedge clk); t++;
    end
    #1 bus.req_valid = 2'b00;
    chk("rr_count", gq.size(), 4);
    if (gq.size() >= 4) begin
      chk("rr_g0", gq[0], 0); chk("rr_g1", gq[1], 1);
      chk("rr_g2", gq[2], 0); chk("rr_g3", gq[3], 1);
    end
    wait_rsps(base + 4, 100);

    // Consumer stall: outputs held, requester 1 kept waiting.
    bus.rsp_ready = 1'b0;
    base = n_rsp;
    @(posedge clk); #1;
    drive(0, 12'h5A5, 12'h3C3, 1'b0);
    wait_acc(0);
    bus.req_valid[0] = 1'b0;
    drive(1, 12'h111, 12'h222, 1'b1);
    t = 0;
    while (!bus.rsp_valid && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("stall_rsp_valid", bus.rsp_valid, 1);
    repeat (10) @(posedge clk);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall_back_idle", bus.rsp_valid, 0);
    chk("stall_grant1", bus.req_ready, 2'b10);
    wait_acc(1);
    bus.req_valid[1] = 1'b0;
    wait_rsps(base + 2, 100);

    // Reset in the second ADD cycle abandons the operation.
    base = n_rsp;
    @(posedge clk); #1;
    drive(0, 12'h003, 12'h004, 1'b0);
    wait_acc(0);
    bus.req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 0);
    chk("arst_rsp_sum",   bus.rsp_sum, 0);
    chk("arst_rsp_cout",  bus.rsp_cout, 0);
    chk("arst_rsp_id",    bus.rsp_id, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    repeat (2) @(posedge clk);
    #1 begin bus.req_valid = 2'b00; rst = 1'b0; end
    single(0, 12'h123, 12'h456, 1'b0);
    chk("post_rst_sum", l_sum, 12'h579); chk("post_rst_cout", l_cout, 0);
    chk("no_ghost_rsp", n_rsp, base + 1);

    // Random traffic from both requesters, random drops and consumer stalls.
    base = n_rsp;
    t = 0;
    while (n_rsp < base + 1000 && t < 30000) begin
      @(posedge clk); #1; t++;
      for (int i = 0; i < 2; i++) begin
        if (acc_pend[i] || !bus.req_valid[i]) begin
          bus.req_a[i*W +: W] = W'($urandom);
          bus.req_b[i*W +: W] = W'($urandom);
          bus.req_cin[i]      = 1'($urandom);
          bus.req_valid[i]    = ($urandom_range(0, 1) == 1);
        end else if ($urandom_range(0, 7) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    chk("rand_ops", n_rsp >= base + 1000, 1);
    t = 0;
    while (busy && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("drain_idle", busy, 0);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
